// File: rtl/counter_mod_prog.sv
// Programmable modulo counter: runtime modulus, direction, match value and
// one-shot/continuous terminal mode, with parallel load and optional restart gap.
module counter_mod_prog #(
    parameter int N      = 8,
    parameter int GAP_EN = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stop,
    input  logic         en,
    input  logic         up_dn,
    input  logic         oneshot,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic [N-1:0] limit,
    input  logic [N-1:0] match_val,
    output logic [N-1:0] count,
    output logic         wrap,
    output logic         match,
    output logic         done,
    output logic         busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t       state_r;
    state_t       state_s;
    logic [N-1:0] count_r;
    logic [N-1:0] count_s;
    logic         wrap_r;
    logic         wrap_s;
    logic [N-1:0] reload_s;
    logic         terminal_s;

    // A load can never place the count outside the programmed range.
    function automatic logic [N-1:0] clamp_to_limit(input logic [N-1:0] val,
                                                    input logic [N-1:0] lim);
        return (val > lim) ? lim : val;
    endfunction

    assign reload_s   = up_dn ? {N{1'b0}} : limit;
    assign terminal_s = up_dn ? (count_r >= limit) : (count_r == {N{1'b0}});

    // Next-state, next-count and wrap decode; stop outranks load outranks start/en.
    always_comb begin
        state_s = state_r;
        count_s = count_r;
        wrap_s  = 1'b0;
        if (stop) begin
            state_s = ST_IDLE;
            count_s = {N{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_s = ST_RUN;
                        count_s = reload_s;
                    end else begin
                        count_s = {N{1'b0}};
                    end
                end
                ST_RUN: begin
                    if (load) begin
                        count_s = clamp_to_limit(load_val, limit);
                    end else if (en) begin
                        if (terminal_s) begin
                            wrap_s = 1'b1;
                            if (oneshot) begin
                                state_s = ST_DONE;
                            end else begin
                                count_s = reload_s;
                                state_s = (GAP_EN != 0) ? ST_GAP : ST_RUN;
                            end
                        end else if (up_dn) begin
                            count_s = count_r + {{(N-1){1'b0}}, 1'b1};
                        end else begin
                            count_s = count_r - {{(N-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        count_s = count_r;
                    end
                end
                ST_GAP: begin
                    state_s = ST_RUN;
                    if (load) begin
                        count_s = clamp_to_limit(load_val, limit);
                    end else begin
                        count_s = count_r;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        state_s = ST_RUN;
                        count_s = reload_s;
                    end else begin
                        count_s = count_r;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    count_s = {N{1'b0}};
                end
            endcase
        end
    end

    // State, count and wrap registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            count_r <= {N{1'b0}};
            wrap_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            count_r <= count_s;
            wrap_r  <= wrap_s;
        end
    end

    assign count = count_r;
    assign wrap  = wrap_r;
    assign match = (count_r == match_val) && (state_r != ST_IDLE);
    assign done  = (state_r == ST_DONE);
    assign busy  = (state_r == ST_RUN) || (state_r == ST_GAP);

endmodule

// File: tb/tb_counter_mod_prog.sv
// Bench for counter_mod_prog: two instances (with and without restart gap)
// checked every cycle against a rule-level reference model, plus directed scenarios.
module tb_counter_mod_prog;

    localparam int N = 8;
    localparam int MODV = 1 << N;

    logic         clk = 1'b0;
    logic         reset, start, stop, en, up_dn, oneshot, load;
    logic [N-1:0] load_val, limit, match_val;

    logic [N-1:0] dut_count [2];
    logic         dut_wrap  [2];
    logic         dut_match [2];
    logic         dut_done  [2];
    logic         dut_busy  [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Model: phase 0=idle 1=run 2=gap 3=done; index 0 has the gap, index 1 not.
    int m_phase [2];
    int m_cnt   [2];
    bit m_wrap  [2];

    always #5 clk = ~clk;

    counter_mod_prog #(.N(N), .GAP_EN(1)) dut_gap (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .en(en),
        .up_dn(up_dn), .oneshot(oneshot), .load(load), .load_val(load_val),
        .limit(limit), .match_val(match_val), .count(dut_count[0]),
        .wrap(dut_wrap[0]), .match(dut_match[0]), .done(dut_done[0]),
        .busy(dut_busy[0])
    );

    counter_mod_prog #(.N(N), .GAP_EN(0)) dut_nogap (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .en(en),
        .up_dn(up_dn), .oneshot(oneshot), .load(load), .load_val(load_val),
        .limit(limit), .match_val(match_val), .count(dut_count[1]),
        .wrap(dut_wrap[1]), .match(dut_match[1]), .done(dut_done[1]),
        .busy(dut_busy[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int g = 0; g < 2; g++) begin
            m_phase[g] = 0;
            m_cnt[g]   = 0;
            m_wrap[g]  = 1'b0;
        end
    endfunction

    // One clock edge of the counter rules, using the inputs present at the edge.
    function automatic void model_step(input int g);
        int lim;
        int lv;
        bit at_end;
        lim = int'(limit);
        lv  = int'(load_val);
        at_end = up_dn ? (m_cnt[g] >= lim) : (m_cnt[g] == 0);
        m_wrap[g] = 1'b0;
        if (!reset) begin
            m_phase[g] = 0;
            m_cnt[g]   = 0;
        end else if (stop) begin
            m_phase[g] = 0;
            m_cnt[g]   = 0;
        end else if (m_phase[g] == 2) begin
            if (load) m_cnt[g] = (lv < lim) ? lv : lim;
            m_phase[g] = 1;
        end else if (m_phase[g] == 1 && load) begin
            m_cnt[g] = (lv < lim) ? lv : lim;
        end else if ((m_phase[g] == 0 || m_phase[g] == 3) && start) begin
            m_phase[g] = 1;
            m_cnt[g]   = up_dn ? 0 : lim;
        end else if (m_phase[g] == 1 && en) begin
            if (at_end) begin
                m_wrap[g] = 1'b1;
                if (oneshot) begin
                    m_phase[g] = 3;
                end else begin
                    m_cnt[g]   = up_dn ? 0 : lim;
                    m_phase[g] = (g == 0) ? 2 : 1;
                end
            end else begin
                m_cnt[g] = up_dn ? (m_cnt[g] + 1) % MODV : (m_cnt[g] + MODV - 1) % MODV;
            end
        end
    endfunction

    task automatic check_all();
        for (int g = 0; g < 2; g++) begin
            check_eq($sformatf("count[%0d]", g), dut_count[g], m_cnt[g]);
            check_eq($sformatf("wrap[%0d]", g),  dut_wrap[g],  m_wrap[g]);
            check_eq($sformatf("match[%0d]", g), dut_match[g],
                     (m_phase[g] != 0 && m_cnt[g] == int'(match_val)) ? 1 : 0);
            check_eq($sformatf("done[%0d]", g),  dut_done[g],  (m_phase[g] == 3) ? 1 : 0);
            check_eq($sformatf("busy[%0d]", g),  dut_busy[g],
                     (m_phase[g] == 1 || m_phase[g] == 2) ? 1 : 0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_all();
    endtask

    // Asynchronous reset pulse between edges; outputs must clear before the next edge.
    task automatic async_reset();
        reset = 1'b0;
        #2;
        model_reset();
        for (int g = 0; g < 2; g++) begin
            check_eq($sformatf("rst_count[%0d]", g), dut_count[g], 0);
            check_eq($sformatf("rst_wrap[%0d]", g),  dut_wrap[g],  0);
            check_eq($sformatf("rst_busy[%0d]", g),  dut_busy[g],  0);
            check_eq($sformatf("rst_done[%0d]", g),  dut_done[g],  0);
            check_eq($sformatf("rst_match[%0d]", g), dut_match[g], 0);
        end
        tick();
        reset = 1'b1;
    endtask

    task automatic idle_inputs();
        start = 1'b0; stop = 1'b0; load = 1'b0;
    endtask

    initial begin
        int up_seq[16] = '{0,1,2,3,4,5,6,0,0,1,2,3,4,5,6,0};
        int dn_seq[6]  = '{3,2,1,0,0,0};
        model_reset();
        reset = 1'b0; start = 1'b0; stop = 1'b0; en = 1'b0; up_dn = 1'b1;
        oneshot = 1'b0; load = 1'b0; load_val = '0; limit = 8'd6; match_val = 8'd4;
        #1;
        tick();
        tick();
        reset = 1'b1;

        // Up, continuous, limit 6, match 4.
        en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("up_first", dut_count[0], 0);
        for (int k = 1; k < 16; k++) begin
            tick();
            check_eq($sformatf("up_seq%0d", k), dut_count[0], up_seq[k]);
            check_eq($sformatf("up_wrap%0d", k), dut_wrap[0], (k == 7 || k == 15) ? 1 : 0);
            check_eq($sformatf("up_match%0d", k), dut_match[0], (up_seq[k] == 4) ? 1 : 0);
        end

        // Reset mid-count at count 5, then nothing moves until start.
        stop = 1'b1; tick(); stop = 1'b0;
        limit = 8'd10; start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check_eq("pre_reset_count", dut_count[0], 5);
        async_reset();
        for (int k = 0; k < 3; k++) tick();
        check_eq("post_reset_idle", dut_count[0], 0);

        // Down, one-shot, limit 3.
        up_dn = 1'b0; oneshot = 1'b1; limit = 8'd3; start = 1'b1;
        tick(); start = 1'b0;
        check_eq("dn_start", dut_count[0], 3);
        for (int k = 1; k < 6; k++) begin
            tick();
            check_eq($sformatf("dn_seq%0d", k), dut_count[0], dn_seq[k]);
            check_eq($sformatf("dn_wrap%0d", k), dut_wrap[0], (k == 4) ? 1 : 0);
        end
        check_eq("dn_done", dut_done[0], 1);
        start = 1'b1; tick(); start = 1'b0;
        check_eq("dn_restart", dut_count[0], 3);
        check_eq("dn_restart_busy", dut_busy[0], 1);

        // Load clamps to limit, then terminal on the next enabled step.
        stop = 1'b1; tick(); stop = 1'b0;
        up_dn = 1'b1; oneshot = 1'b0; limit = 8'd10; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
        check_eq("ld_pre", dut_count[0], 2);
        load = 1'b1; load_val = 8'd15; tick(); load = 1'b0;
        check_eq("ld_clamp", dut_count[0], 10);
        tick();
        check_eq("ld_wrap", dut_wrap[0], 1);
        check_eq("ld_wrap_count", dut_count[0], 0);
        stop = 1'b1; load = 1'b1; tick(); idle_inputs();
        check_eq("stop_load_busy", dut_busy[0], 0);

        // Randomized run.
        for (int c = 0; c < 4000; c++) begin
            stop  = ($urandom_range(0, 39) == 0);
            load  = ($urandom_range(0, 11) == 0);
            start = ($urandom_range(0, 5) == 0);
            en    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) up_dn = ~up_dn;
            if ($urandom_range(0, 39) == 0) oneshot = ~oneshot;
            if ($urandom_range(0, 24) == 0)
                limit = ($urandom_range(0, 7) == 0) ? N'($urandom_range(0, 255))
                                                    : N'($urandom_range(0, 12));
            if ($urandom_range(0, 19) == 0) match_val = N'($urandom_range(0, 12));
            load_val = N'($urandom_range(0, 20));
            if ($urandom_range(0, 599) == 0) begin
                async_reset();
            end else begin
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
